// File: rtl/mul_arb_pkg.sv
// Shared constants, tag type and index helper for the multiplier arbiter.
package mul_arb_pkg;

  localparam int MUL_W       = 4;
  localparam int PROD_W      = 8;
  localparam int MUL_LAT     = 2;
  localparam int NUM_REQ_DEF = 4;
  localparam int ID_W        = $clog2(NUM_REQ_DEF);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } mul_tag_t;

  function automatic int wrap_add(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: one-hot grant plus encoded index.
// With MUL_ARB_PRIO0_EN defined, requester 0 overrides the rotation and leaves ptr alone.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               ptr_adv
);
  import mul_arb_pkg::*;

  logic [NUM_REQ-1:0] rr_grant;
  logic [ID_W-1:0]    rr_idx;
  logic [ID_W-1:0]    scan_idx;
  logic               rr_hit;

  always_comb begin
    rr_grant = '0;
    rr_idx   = '0;
    rr_hit   = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = ID_W'(wrap_add(int'(ptr), k, NUM_REQ));
      if (!rr_hit && req[scan_idx]) begin
        rr_hit           = 1'b1;
        rr_grant         = '0;
        rr_grant[scan_idx] = 1'b1;
        rr_idx           = scan_idx;
      end
    end
  end

  always_comb begin
    grant     = rr_grant;
    grant_idx = rr_idx;
    ptr_adv   = rr_hit;
`ifdef MUL_ARB_PRIO0_EN
    // Fixed-priority path: the rotation among 1..NUM_REQ-1 keeps its place.
    if (req[0]) begin
      grant     = '0;
      grant[0]  = 1'b1;
      grant_idx = '0;
      ptr_adv   = 1'b0;
    end
`endif
    if (!en) begin
      grant     = '0;
      grant_idx = '0;
      ptr_adv   = 1'b0;
    end
  end

endmodule

// File: rtl/mul_pipe_arbiter.sv
// Front end sharing one pipelined 4x4 multiplier among NUM_REQ requesters with ID tagging.
// Build option MUL_ARB_PRIO0_EN (inside rr_arbiter) gives requester 0 fixed top priority.
module mul_pipe_arbiter #(
  parameter int NUM_REQ = mul_arb_pkg::NUM_REQ_DEF,
  parameter int MUL_LAT = mul_arb_pkg::MUL_LAT,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   arb_en,
  input  logic [NUM_REQ-1:0]                     req_valid,
  output logic [NUM_REQ-1:0]                     req_ready,
  input  logic [NUM_REQ*mul_arb_pkg::MUL_W-1:0]  req_a,
  input  logic [NUM_REQ*mul_arb_pkg::MUL_W-1:0]  req_b,
  output logic [mul_arb_pkg::MUL_W-1:0]          mul_a,
  output logic [mul_arb_pkg::MUL_W-1:0]          mul_b,
  input  logic [mul_arb_pkg::PROD_W-1:0]         mul_in,
  output logic                                   rsp_valid,
  output logic [ID_W-1:0]                        rsp_id,
  output logic [mul_arb_pkg::PROD_W-1:0]         rsp_data,
  output logic                                   busy
);
  import mul_arb_pkg::*;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               ptr_adv;
  logic               issue;
  logic [ID_W-1:0]    ptr_reg, ptr_next;
  logic [MUL_W-1:0]   mul_a_reg, mul_b_reg, mul_a_next, mul_b_next;
  logic [MUL_W-1:0]   op_a [NUM_REQ];
  logic [MUL_W-1:0]   op_b [NUM_REQ];
  tag_t               issue_next;
  tag_t               tag_reg [MUL_LAT+1];
  logic [MUL_LAT:0]   tag_valid;

  genvar gi;
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_ops
    assign op_a[gi] = req_a[gi*MUL_W +: MUL_W];
    assign op_b[gi] = req_b[gi*MUL_W +: MUL_W];
  end

  // Gating enable with rst_n keeps req_ready low for the whole reset window.
  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req       (req_valid),
    .en        (arb_en & rst_n),
    .ptr       (ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx),
    .ptr_adv   (ptr_adv)
  );

  assign req_ready = grant;
  assign issue     = |grant;

  always_comb begin
    mul_a_next = '0;
    mul_b_next = '0;
    issue_next = '0;
    ptr_next   = ptr_reg;
    if (issue) begin
      mul_a_next = op_a[grant_idx];
      mul_b_next = op_b[grant_idx];
      issue_next = tag_t'{valid: 1'b1, id: grant_idx};
    end
    if (ptr_adv) ptr_next = ID_W'(wrap_add(int'(grant_idx), 1, NUM_REQ));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a_reg  <= '0;
      mul_b_reg  <= '0;
      ptr_reg    <= '0;
      tag_reg[0] <= '0;
    end else begin
      mul_a_reg  <= mul_a_next;
      mul_b_reg  <= mul_b_next;
      ptr_reg    <= ptr_next;
      tag_reg[0] <= issue_next;
    end
  end

  // Tag stage k lines up with the operand pair k registers deep in the multiplier.
  for (gi = 1; gi <= MUL_LAT; gi++) begin : g_tag
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tag_reg[gi] <= '0;
      else        tag_reg[gi] <= tag_reg[gi-1];
    end
  end

  for (gi = 0; gi <= MUL_LAT; gi++) begin : g_valid
    assign tag_valid[gi] = tag_reg[gi].valid;
  end

  assign mul_a     = mul_a_reg;
  assign mul_b     = mul_b_reg;
  assign busy      = |tag_valid;
  assign rsp_valid = tag_reg[MUL_LAT].valid;
  assign rsp_id    = tag_reg[MUL_LAT].id;
  assign rsp_data  = rsp_valid ? mul_in : '0;

endmodule
